ret_stack: RTL and testbench
============================

RET_STACK -- requirements
Module: ret_stack

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of each stored entry.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of entries; legal values are powers of two, 2 or more.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port push  input  1  SHALL request a write of push_data onto the top.
REQ-006 Port push_data  input  DATA_WIDTH  SHALL be the value to push.
REQ-007 Port pop  input  1  SHALL request removal of the top entry.
REQ-008 Port clear  input  1  SHALL synchronously empty the stack.
REQ-009 Port top_data  output  DATA_WIDTH  SHALL be the current top entry (the value returned by a pop this cycle).
REQ-010 Port count  output  $clog2(DEPTH+1)  SHALL be the number of valid entries.
REQ-011 Port empty  output  1  SHALL be high when count is 0.
REQ-012 Port full  output  1  SHALL be high when count equals DEPTH.
REQ-013 Port overflow  output  1  SHALL be a sticky flag: a push met a full stack.
REQ-014 Port underflow  output  1  SHALL be a sticky flag: a pop met an empty stack.

Function
REQ-015 top_data SHALL reflect the registered state combinationally: entry at index count-1 when not empty, all zeros when empty.
REQ-016 Push only, not full: SHALL write push_data at the top index and increment count at the clock edge; the new value appears on top_data in the next cycle.
REQ-017 Pop only, not empty: SHALL decrement count at the clock edge; the caller captures top_data in the same cycle pop is high.
REQ-018 Push and pop together, not empty: SHALL overwrite the top entry with push_data and leave count unchanged; the old top is on top_data during that cycle.
REQ-019 Push and pop together, empty: SHALL act as push only and SHALL NOT set underflow.
REQ-020 Push and pop together, full: SHALL follow REQ-018 and SHALL NOT set overflow.
REQ-021 Pop only, empty: state SHALL be unchanged, underflow SHALL set at the edge, and top_data SHALL read 0.
REQ-022 Push only, full: SHALL follow the Configuration section.
REQ-023 clear SHALL take priority over push and pop: count and both sticky flags go to 0 at the edge.
REQ-024 Storage SHALL be DEPTH by DATA_WIDTH; the block SHALL keep an internal circular base index so wrap mode needs no data movement.
REQ-025 The block SHALL be fully synchronous except for rst; it SHALL contain no latches and no combinational loops.

Reset
REQ-026 While rst is high: count SHALL be 0, empty 1, full 0, overflow 0, underflow 0, top_data 0, and the base index 0.
REQ-027 Storage contents SHALL NOT be reset, and SHALL never be visible while empty.
REQ-028 rst asserted during operation SHALL discard any push or pop in that cycle; operation resumes on the first edge after rst falls.

Configuration
REQ-029 Macro RET_STACK_WRAP_EN defined: push-only when full SHALL overwrite the oldest entry, advancing the base index modulo DEPTH. Count stays DEPTH, push_data becomes the top, and overflow sets.
REQ-030 Macro RET_STACK_WRAP_EN undefined: push-only when full SHALL be ignored (storage and count unchanged) and overflow sets.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-031 Reset, then push 0x11, 0x22, 0x33 -> count=3, top_data=0x33; pop three times -> top_data reads 0x33, 0x22, 0x11 in the pop cycles; then empty=1 and top_data=0x00.
REQ-032 Pop on an empty stack -> underflow=1, count=0; then clear -> underflow=0.
REQ-033 Push 0xA1..0xA4 (full=1), then push 0xA5 -> without the macro: top_data=0xA4, overflow=1; with RET_STACK_WRAP_EN: top_data=0xA5, and four pops return 0xA5, 0xA4, 0xA3, 0xA2.
REQ-034 Stack holds 0x10, 0x20; push 0x30 with pop in one cycle -> count=2, top_data=0x30; pop -> top_data=0x10.
REQ-035 Push plus pop on an empty stack with 0x5A -> count=1, top_data=0x5A, underflow=0.
REQ-036 Assert rst mid-push sequence at count=2 -> immediately count=0 and empty=1; a push after rst falls lands at index 0.

Source files
------------

// File: rtl/ret_stack.sv
// LIFO return-address stack with circular storage, sticky overflow/underflow flags.
// Define RET_STACK_WRAP_EN to make a push onto a full stack overwrite the oldest entry.
module ret_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [DATA_WIDTH-1:0]      top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         base;
  logic [AW-1:0]         top_idx;
  logic [AW-1:0]         push_idx;

  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [CW-1:0]         nxt_count;
  logic [AW-1:0]         nxt_base;
  logic                  set_ovf;
  logic                  set_unf;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Indices wrap for free because DEPTH is a power of two.
  assign top_idx  = base + AW'(count) - AW'(1);
  assign push_idx = base + AW'(count);

  assign top_data = empty ? '0 : mem[top_idx];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wr_en     = 1'b0;
    wr_idx    = push_idx;
    nxt_count = count;
    nxt_base  = base;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (clear) begin
      wr_en = 1'b0;
    end else if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push && !full) begin
      wr_en     = 1'b1;
      nxt_count = count + CW'(1);
    end else if (push) begin
      set_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
      // The oldest slot sits at base; reuse it and slide the window forward.
      wr_en    = 1'b1;
      wr_idx   = base;
      nxt_base = base + AW'(1);
`endif
    end else if (pop && !empty) begin
      nxt_count = count - CW'(1);
    end else if (pop) begin
      set_unf = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      base      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      base      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= nxt_count;
      base      <= nxt_base;
      overflow  <= overflow | set_ovf;
      underflow <= underflow | set_unf;
    end
  end

  // NOTE: storage is deliberately not reset; empty masks it on top_data.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= push_data;
  end

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack (DATA_WIDTH=8, DEPTH=4) with a queue-based reference
// model and a scoreboard of expected pop values.
module tb_ret_stack;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic          clear;
  logic [DW-1:0] top_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [DW-1:0] exp_q[$];

  ret_stack #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .clear(clear), .top_data(top_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DW-1:0] t;
    t = (model.size() == 0) ? '0 : model[model.size()-1];
    check({tag, " count"},     32'(count),     32'(model.size()));
    check({tag, " empty"},     32'(empty),     32'(model.size() == 0));
    check({tag, " full"},      32'(full),      32'(model.size() == DP));
    check({tag, " top"},       32'(top_data),  32'(t));
    check({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // One clock cycle of stimulus; pop cycles score the value on top_data before the edge.
  task automatic op(input string tag, input logic p, input logic q, input logic c,
                    input logic [DW-1:0] d);
    logic [DW-1:0] e;
    @(negedge clk);
    push = p; pop = q; clear = c; push_data = d;
    #2;
    if (q && !c) begin
      exp_q.push_back((model.size() == 0) ? '0 : model[model.size()-1]);
      e = exp_q.pop_front();
      check({tag, " pop value"}, 32'(top_data), 32'(e));
    end
    if (c) begin
      model.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (p && q && model.size() > 0) begin
      model[model.size()-1] = d;
    end else if (p && model.size() < DP) begin
      model.push_back(d);
    end else if (p) begin
      m_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
      void'(model.pop_front());
      model.push_back(d);
`endif
    end else if (q && model.size() > 0) begin
      void'(model.pop_back());
    end else if (q) begin
      m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
    #1;
    check_state("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic LIFO order.
    op("push11", 1, 0, 0, 8'h11);
    op("push22", 1, 0, 0, 8'h22);
    op("push33", 1, 0, 0, 8'h33);
    check_state("three pushed");
    check("top is 33", 32'(top_data), 32'h33);
    op("pop1", 0, 1, 0, 8'h00);
    op("pop2", 0, 1, 0, 8'h00);
    op("pop3", 0, 1, 0, 8'h00);
    check_state("drained");

    // Underflow and clear.
    op("pop_empty", 0, 1, 0, 8'h00);
    check_state("underflow");
    check("underflow set", 32'(underflow), 32'h1);
    op("clear1", 0, 0, 1, 8'h00);
    check_state("after clear");

    // Full and push-when-full.
    for (int i = 1; i <= 4; i++) op("fill", 1, 0, 0, 8'(8'hA0 + i));
    check_state("full");
    op("push_full", 1, 0, 0, 8'hA5);
    check_state("push when full");
`ifdef RET_STACK_WRAP_EN
    check("wrap top", 32'(top_data), 32'hA5);
`else
    check("nowrap top", 32'(top_data), 32'hA4);
`endif
    check("overflow set", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) op("drain", 0, 1, 0, 8'h00);
    check_state("drained full");
    op("clear2", 0, 0, 1, 8'h00);

    // Push and pop together on a non-empty stack.
    op("push10", 1, 0, 0, 8'h10);
    op("push20", 1, 0, 0, 8'h20);
    op("pushpop30", 1, 1, 0, 8'h30);
    check_state("replace top");
    check("replaced top", 32'(top_data), 32'h30);
    op("pop30", 0, 1, 0, 8'h00);
    check("top after pop", 32'(top_data), 32'h10);
    op("clear3", 0, 0, 1, 8'h00);

    // Push and pop together on an empty stack.
    op("pushpop5a", 1, 1, 0, 8'h5A);
    check_state("pushpop empty");
    check("no underflow", 32'(underflow), 32'h0);
    op("clear4", 0, 0, 1, 8'h00);

    // Async reset mid-sequence discards the in-flight push.
    op("push01", 1, 0, 0, 8'h01);
    op("push02", 1, 0, 0, 8'h02);
    @(negedge clk);
    push = 1'b1; push_data = 8'h03; rst = 1'b1;
    #1;
    model.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state("async reset");
    @(posedge clk); #1;
    check_state("reset held with push");
    @(negedge clk);
    rst = 1'b0; push = 1'b0; push_data = '0;
    op("push77", 1, 0, 0, 8'h77);
    check_state("push after reset");
    op("pop77", 0, 1, 0, 8'h00);
    check_state("empty after reset test");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
